// File: rtl/x_mult_resp_pkg.sv
// x_mult_resp_pkg
// Shared defaults and result-record layout for the multiplier response path.
// The result queue stores one packed record per product, laid out from MSB
// to LSB as {data[WIDTH-1:0], ovf, tag[TAG_W-1:0]}. The helpers below give
// the record width and field offsets for any WIDTH/TAG_W combination.
package x_mult_resp_pkg;

    localparam int X_WIDTH   = 32;
    localparam int X_TAG_W   = 5;
    localparam int X_LATENCY = 2;
    localparam int X_DEPTH   = 2;

    // Total bits in one result record.
    function automatic int rec_width(input int width, input int tag_w);
        return width + 1 + tag_w;
    endfunction

    // Bit position of the overflow flag; the tag occupies the bits below it.
    function automatic int rec_ovf_pos(input int tag_w);
        return tag_w;
    endfunction

    // LSB of the data field, directly above the overflow flag.
    function automatic int rec_data_lsb(input int tag_w);
        return tag_w + 1;
    endfunction

endpackage

// File: rtl/x_mult_resp_fifo.sv
// x_mult_resp_fifo
// Small synchronous FIFO with registered storage. The head entry is always
// presented on dout straight from a flop. Pointers wrap modulo D, so D does
// not have to be a power of two.
// Ports:
//   clk    in   rising-edge clock
//   clrn   in   asynchronous active-low reset (clears storage and pointers)
//   push   in   write din this cycle (ignored when full unless popping too)
//   din    in   W-bit write data
//   pop    in   drop the head entry this cycle (ignored when empty)
//   dout   out  W-bit head entry
//   full   out  D entries held
//   empty  out  no entries held
//   count  out  number of entries held
module x_mult_resp_fifo
    import x_mult_resp_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(D+1)-1:0]   count
);

    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_write;
    logic          do_read;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(D));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same
    // cycle; in that case the write lands in the slot being vacated.
    always_comb begin
        do_read  = pop && !empty;
        do_write = push && (!full || do_read);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_read) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_write, do_read})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/x_mult_resp.sv
// x_mult_resp
// Receiving end of the multiplier's fixed-latency valid delay line.
// Issue side hands out credits so that in-flight plus queued ops never exceed
// DEPTH. Result side pairs each emerging product with the oldest outstanding
// tag, flags signed-WIDTH overflow and queues the record for writeback, so
// the non-stallable multiplier never loses a product.
// Ports:
//   clk          in   rising-edge clock
//   clrn         in   asynchronous active-low reset
//   issue_valid  in   decode requests a multiply
//   issue_ready  out  credit available (accept = valid && ready)
//   issue_tag    in   destination tag of the issuing op
//   mul_valid    in   delayed valid from the delay line
//   mul_product  in   2*WIDTH signed product qualified by mul_valid
//   res_valid    out  a result is at the queue head
//   res_ready    in   writeback consumes the head this cycle
//   res_data     out  low WIDTH bits of the head product
//   res_ovf      out  head product does not fit in signed WIDTH
//   res_tag      out  tag of the head result
//   busy         out  any op in flight or queued
//   proto_err    out  sticky: mul_valid arrived with no outstanding tag
module x_mult_resp
    import x_mult_resp_pkg::*;
#(
    parameter int WIDTH   = X_WIDTH,
    parameter int LATENCY = X_LATENCY,
    parameter int DEPTH   = X_DEPTH,
    parameter int TAG_W   = X_TAG_W
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [TAG_W-1:0]   issue_tag,
    input  logic               mul_valid,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_ovf,
    output logic [TAG_W-1:0]   res_tag,
    output logic               busy,
    output logic               proto_err
);

    localparam int REC_W    = rec_width(WIDTH, TAG_W);
    localparam int OVF_POS  = rec_ovf_pos(TAG_W);
    localparam int DATA_LSB = rec_data_lsb(TAG_W);
    localparam int OW       = $clog2(DEPTH + 1);
    localparam int MW       = $clog2(LATENCY + 1);

    logic [MW-1:0]    mask_cnt_q, mask_cnt_d;
    logic [OW-1:0]    out_cnt_q, out_cnt_d;
    logic             proto_err_q, proto_err_d;

    logic             mask_done;
    logic             accept;
    logic             res_pop;
    logic             mul_live;
    logic             tag_pop;
    logic             tag_empty;
    logic             tag_full;
    logic [OW-1:0]    tag_count;
    logic [TAG_W-1:0] tag_head;
    logic             res_empty;
    logic             res_full;
    logic [OW-1:0]    res_count;
    logic [REC_W-1:0] res_head;
    logic [REC_W-1:0] res_din;
    logic [WIDTH:0]   prod_hi;
    logic             prod_ovf;

    // The delay line keeps whatever it held across reset, so for LATENCY
    // cycles after release its valids belong to ops from before reset.
    assign mask_done   = (mask_cnt_q == '0);
    assign issue_ready = mask_done && (out_cnt_q < OW'(DEPTH));
    assign accept      = issue_valid && issue_ready;
    assign mul_live    = mul_valid && mask_done;
    assign tag_pop     = mul_live && !tag_empty;
    assign res_valid   = !res_empty;
    assign res_pop     = res_valid && res_ready;

    // The product fits in signed WIDTH only when the top WIDTH+1 bits are a
    // pure sign extension.
    assign prod_hi  = mul_product[2*WIDTH-1:WIDTH-1];
    assign prod_ovf = !((&prod_hi) || !(|prod_hi));
    assign res_din  = {mul_product[WIDTH-1:0], prod_ovf, tag_head};

    assign res_data  = res_valid ? res_head[DATA_LSB +: WIDTH] : '0;
    assign res_ovf   = res_valid ? res_head[OVF_POS] : 1'b0;
    assign res_tag   = res_valid ? res_head[TAG_W-1:0] : '0;
    assign busy      = (out_cnt_q != '0);
    assign proto_err = proto_err_q;

    always_comb begin
        mask_cnt_d  = mask_done ? mask_cnt_q : mask_cnt_q - 1'b1;
        out_cnt_d   = out_cnt_q;
        proto_err_d = proto_err_q | (mul_live && tag_empty);
        unique case ({accept, res_pop})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mask_cnt_q  <= MW'(LATENCY);
            out_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            mask_cnt_q  <= mask_cnt_d;
            out_cnt_q   <= out_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    x_mult_resp_fifo #(
        .W (TAG_W),
        .D (DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .clrn  (clrn),
        .push  (accept),
        .din   (issue_tag),
        .pop   (tag_pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    x_mult_resp_fifo #(
        .W (REC_W),
        .D (DEPTH)
    ) u_res_q (
        .clk   (clk),
        .clrn  (clrn),
        .push  (tag_pop),
        .din   (res_din),
        .pop   (res_pop),
        .dout  (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    // Every outstanding op is either waiting for its product (tag queue) or
    // waiting for writeback (result queue); credits keep both from overflowing.
    assert property (@(posedge clk) disable iff (!clrn)
        ({1'b0, out_cnt_q} == ({1'b0, tag_count} + {1'b0, res_count})));
    assert property (@(posedge clk) disable iff (!clrn)
        !(accept && tag_full));
    assert property (@(posedge clk) disable iff (!clrn)
        !(tag_pop && res_full && !res_pop));

endmodule

// File: tb/tb_x_mult_resp.sv
// tb_x_mult_resp
// Directed bench for x_mult_resp. A queue-based model of outstanding tags and
// pending results is checked against the DUT on every falling clock edge, and
// hand-computed literals pin the key points of each scenario.
module tb_x_mult_resp;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 2;
    localparam int TAG_W   = 5;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        clrn;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_tag;
    logic        mul_valid;
    logic [63:0] mul_product;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_ovf;
    logic [4:0]  res_tag;
    logic        busy;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic [4:0]  tag;
    } res_t;

    res_t       m_resq[$];
    logic [4:0] m_tagq[$];
    int         m_mask;
    logic       m_perr;

    always #5 clk = ~clk;

    x_mult_resp #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_tag   (issue_tag),
        .mul_valid   (mul_valid),
        .mul_product (mul_product),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_ovf     (res_ovf),
        .res_tag     (res_tag),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    function automatic logic model_ovf(input logic [63:0] p);
        longint s;
        s = longint'(p);
        return (s > MAXV) || (s < MINV);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [4:0] tag, input logic mv,
                                 input logic [63:0] prod, input logic rr);
        issue_valid = iv;
        issue_tag   = tag;
        mul_valid   = mv;
        mul_product = prod;
        res_ready   = rr;
        @(posedge clk);
        #1;
    endtask

    // One op end to end: issue, product two cycles later, then pop.
    task automatic doOne(input logic [4:0] tag, input logic [63:0] prod,
                         input logic [31:0] exp_data, input logic exp_ovf);
        applyStimulus(1'b1, tag, 1'b0, 64'h0, 1'b1);
        checkOutput("busy_after_issue", busy, 1);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b1, prod, 1'b1);
        checkOutput("one_res_valid", res_valid, 1);
        checkOutput("one_res_data", res_data, exp_data);
        checkOutput("one_res_tag", res_tag, tag);
        checkOutput("one_res_ovf", res_ovf, exp_ovf);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        checkOutput("one_res_valid_after_pop", res_valid, 0);
        checkOutput("one_busy_after_pop", busy, 0);
    endtask

    // Model: outstanding ops are exactly the waiting tags plus pending results.
    initial begin
        logic exp_ready;
        logic exp_valid;
        logic acc;
        logic pop;
        res_t r;
        forever begin
            @(negedge clk);
            if (!clrn) begin
                m_resq.delete();
                m_tagq.delete();
                m_mask = LATENCY;
                m_perr = 1'b0;
            end
            exp_ready = clrn && (m_mask == 0) && ((m_tagq.size() + m_resq.size()) < DEPTH);
            exp_valid = (m_resq.size() != 0);
            checkOutput("cyc_issue_ready", issue_ready, exp_ready);
            checkOutput("cyc_res_valid", res_valid, exp_valid);
            checkOutput("cyc_res_data", res_data, exp_valid ? m_resq[0].data : 32'h0);
            checkOutput("cyc_res_ovf", res_ovf, exp_valid ? m_resq[0].ovf : 1'b0);
            checkOutput("cyc_res_tag", res_tag, exp_valid ? m_resq[0].tag : 5'h0);
            checkOutput("cyc_busy", busy, (m_tagq.size() + m_resq.size()) != 0);
            checkOutput("cyc_proto_err", proto_err, m_perr);
            if (clrn) begin
                acc = issue_valid && exp_ready;
                pop = exp_valid && res_ready;
                if (pop) m_resq.delete(0);
                if (mul_valid && m_mask == 0) begin
                    if (m_tagq.size() != 0) begin
                        r.tag  = m_tagq.pop_front();
                        r.data = mul_product[31:0];
                        r.ovf  = model_ovf(mul_product);
                        m_resq.push_back(r);
                    end else begin
                        m_perr = 1'b1;
                    end
                end
                if (acc) m_tagq.push_back(issue_tag);
                if (m_mask > 0) m_mask--;
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: time limit reached, sequence did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        clrn        = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = 5'd0;
        mul_valid   = 1'b0;
        mul_product = 64'h0;
        res_ready   = 1'b0;
        @(posedge clk);
        #1;

        // Reset held, stale valids present.
        applyStimulus(1'b1, 5'd3, 1'b1, 64'h5, 1'b1);
        checkOutput("rst_issue_ready", issue_ready, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_res_tag", res_tag, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_proto_err", proto_err, 0);

        // Release with stale mul_valid for two cycles.
        clrn = 1'b1;
        applyStimulus(1'b1, 5'd9, 1'b1, 64'h7, 1'b1);
        checkOutput("mask1_issue_ready", issue_ready, 0);
        checkOutput("mask1_res_valid", res_valid, 0);
        applyStimulus(1'b1, 5'd9, 1'b1, 64'h7, 1'b1);
        checkOutput("mask2_issue_ready", issue_ready, 1);
        checkOutput("mask2_res_valid", res_valid, 0);
        checkOutput("mask2_proto_err", proto_err, 0);
        checkOutput("mask2_busy", busy, 0);

        // Basic op and overflow boundaries.
        doOne(5'd5, 64'h0000_0000_0000_0007, 32'h0000_0007, 1'b0);
        doOne(5'd10, 64'h0000_0001_0000_0000, 32'h0000_0000, 1'b1);
        doOne(5'd11, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0);
        doOne(5'd12, 64'hFFFF_FFFF_7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        doOne(5'd13, 64'h0000_0000_7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);

        // Back-pressure: two ops, credits exhausted, head held.
        applyStimulus(1'b1, 5'd1, 1'b0, 64'h0, 1'b0);
        checkOutput("bp_ready_after_first", issue_ready, 1);
        applyStimulus(1'b1, 5'd2, 1'b0, 64'h0, 1'b0);
        checkOutput("bp_ready_after_second", issue_ready, 0);
        applyStimulus(1'b0, 5'd0, 1'b1, 64'h11, 1'b0);
        checkOutput("bp_head_tag1", res_tag, 1);
        applyStimulus(1'b0, 5'd0, 1'b1, 64'h22, 1'b0);
        checkOutput("bp_head_tag1_held", res_tag, 1);
        checkOutput("bp_head_data_held", res_data, 32'h11);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b0);
        checkOutput("bp_head_tag1_stall", res_tag, 1);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        checkOutput("bp_head_tag2", res_tag, 2);
        checkOutput("bp_head_data2", res_data, 32'h22);
        checkOutput("bp_ready_after_pop", issue_ready, 1);
        applyStimulus(1'b1, 5'd3, 1'b0, 64'h0, 1'b1);
        checkOutput("bp_pop_issue_valid", res_valid, 0);
        checkOutput("bp_pop_issue_busy", busy, 1);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b1, 64'h33, 1'b1);
        checkOutput("bp_tag3", res_tag, 3);
        checkOutput("bp_data3", res_data, 32'h33);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        checkOutput("bp_busy_end", busy, 0);

        // Unsolicited product.
        applyStimulus(1'b0, 5'd0, 1'b1, 64'h44, 1'b1);
        checkOutput("perr_set", proto_err, 1);
        checkOutput("perr_no_res", res_valid, 0);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        checkOutput("perr_sticky", proto_err, 1);

        // Reset with two ops in flight.
        applyStimulus(1'b1, 5'd6, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b1, 5'd7, 1'b0, 64'h0, 1'b1);
        checkOutput("inflight_busy", busy, 1);
        checkOutput("inflight_ready", issue_ready, 0);
        clrn = 1'b0;
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_ready", issue_ready, 0);
        checkOutput("async_rst_res_valid", res_valid, 0);
        checkOutput("async_rst_proto_err", proto_err, 0);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b1);
        clrn = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b1, 64'h66, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b1, 64'h77, 1'b1);
        checkOutput("stale_res_valid", res_valid, 0);
        checkOutput("stale_proto_err", proto_err, 0);
        checkOutput("stale_ready", issue_ready, 1);
        doOne(5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFE, 1'b0);

        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
